// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcode encodings, datapath width and the reset NOP.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    NPC_SEQ  = 2'd0,
    NPC_REL  = 2'd1,
    NPC_JALR = 2'd2
  } npc_kind_e;

  // Resolves the next-PC kind; JALR outranks JAL, which outranks a taken branch.
  function automatic npc_kind_e npc_kind(input logic is_branch, input logic is_jal,
                                         input logic is_jalr, input logic take_branch);
    if (is_jalr)
      return NPC_JALR;
    else if (is_jal || (is_branch && take_branch))
      return NPC_REL;
    else
      return NPC_SEQ;
  endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-PC target selection and word-alignment check.
module pc_target_calc
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] pc_old,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] imm,
  input  logic            is_branch,
  input  logic            is_jal,
  input  logic            is_jalr,
  input  logic            take_branch,
  output logic [XLEN-1:0] target,
  output logic            target_misaligned
);

  logic [XLEN-1:0] seq_target;
  logic [XLEN-1:0] rel_target;
  logic [XLEN-1:0] jalr_sum;
  npc_kind_e       kind;

  assign seq_target = pc_old + 32'd4;
  assign rel_target = pc_old + imm;
  assign jalr_sum   = rs1_data + imm;
  assign kind       = npc_kind(is_branch, is_jal, is_jalr, take_branch);

  always_comb begin
    target = seq_target;
    case (kind)
      NPC_REL:  target = rel_target;
      // JALR clears bit 0 only; bit 1 is left for the alignment check.
      NPC_JALR: target = jalr_sum & ~32'h1;
      default:  target = seq_target;
    endcase
  end

  assign target_misaligned = |target[1:0];

endmodule

// File: rtl/pc_fetch_unit.sv
// PC / instruction-register stage: holds pc, pc_old, IR, sticky misaligned flag
// and the retired-instruction counter.
module pc_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ir_write,
  input  logic             pc_write,
  input  logic             is_branch,
  input  logic             is_jal,
  input  logic             is_jalr,
  input  logic             take_branch,
  input  logic [31:0]      imm,
  input  logic [31:0]      rs1_data,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      pc,
  output logic [31:0]      pc_old,
  output logic [31:0]      pc_plus4,
  output logic [31:0]      instr,
  output logic [6:0]       opcode,
  output logic             misaligned,
  output logic [CNT_W-1:0] instret
);

  logic [31:0] pc_reg;
  logic [31:0] pc_old_reg;
  logic [31:0] instr_reg;
  logic        misaligned_reg;
  logic [CNT_W-1:0] instret_reg;

  logic [31:0] target;
  logic        target_misaligned;
  logic        commit_ok;

  pc_target_calc u_target (
    .pc_old            (pc_old_reg),
    .rs1_data          (rs1_data),
    .imm               (imm),
    .is_branch         (is_branch),
    .is_jal            (is_jal),
    .is_jalr           (is_jalr),
    .take_branch       (take_branch),
    .target            (target),
    .target_misaligned (target_misaligned)
  );

  assign commit_ok = pc_write && !target_misaligned;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg <= RESET_PC;
    end else if (commit_ok) begin
      pc_reg <= target;
    end
  end

  // pc_old samples the pre-edge pc, so a same-cycle commit is not visible here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_old_reg <= RESET_PC;
      instr_reg  <= NOP_INSTR;
    end else if (ir_write) begin
      pc_old_reg <= pc_reg;
      instr_reg  <= imem_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misaligned_reg <= 1'b0;
    end else if (pc_write && target_misaligned) begin
      misaligned_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret_reg <= '0;
    end else if (commit_ok) begin
      instret_reg <= instret_reg + 1'b1;
    end
  end

  assign pc         = pc_reg;
  assign pc_old     = pc_old_reg;
  assign pc_plus4   = pc_old_reg + 32'd4;
  assign instr      = instr_reg;
  assign opcode     = instr_reg[6:0];
  assign misaligned = misaligned_reg;
  assign instret    = instret_reg;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: per-cycle model comparison plus directed literal checks.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ir_write, pc_write, is_branch, is_jal, is_jalr, take_branch;
  logic [31:0] imm, rs1_data, imem_rdata;

  logic [31:0] pc, pc_old, pc_plus4, instr;
  logic [6:0]  opcode;
  logic        misaligned;
  logic [31:0] instret;

  logic [31:0] pc4, pc_old4, pc_plus4_4, instr4;
  logic [6:0]  opcode4;
  logic        misaligned4;
  logic [3:0]  instret4;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Behavioural model state
  logic [31:0] m_pc, m_pc_old, m_instr, m_instret;
  logic        m_mis;

  always #5 clk = ~clk;

  pc_fetch_unit dut (
    .clk(clk), .rst(rst), .ir_write(ir_write), .pc_write(pc_write),
    .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr), .take_branch(take_branch),
    .imm(imm), .rs1_data(rs1_data), .imem_rdata(imem_rdata),
    .pc(pc), .pc_old(pc_old), .pc_plus4(pc_plus4), .instr(instr), .opcode(opcode),
    .misaligned(misaligned), .instret(instret)
  );

  pc_fetch_unit #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .ir_write(ir_write), .pc_write(pc_write),
    .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr), .take_branch(take_branch),
    .imm(imm), .rs1_data(rs1_data), .imem_rdata(imem_rdata),
    .pc(pc4), .pc_old(pc_old4), .pc_plus4(pc_plus4_4), .instr(instr4), .opcode(opcode4),
    .misaligned(misaligned4), .instret(instret4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_pc_old = 32'h0; m_instr = 32'h0000_0013;
    m_instret = 32'h0; m_mis = 1'b0;
  endtask

  // Every cycle: all DUT outputs against the model.
  always @(negedge clk) begin
    if (!rst) begin
      chk("m_pc", pc, m_pc);
      chk("m_pc_old", pc_old, m_pc_old);
      chk("m_pc_plus4", pc_plus4, m_pc_old + 32'd4);
      chk("m_instr", instr, m_instr);
      chk("m_opcode", {25'd0, opcode}, {25'd0, m_instr[6:0]});
      chk("m_misaligned", {31'd0, misaligned}, {31'd0, m_mis});
      chk("m_instret", instret, m_instret);
      chk("m_instret4", {28'd0, instret4}, {28'd0, m_instret[3:0]});
    end
  end

  // One clock cycle of stimulus; the model advances from spec rules at the edge.
  task automatic cyc(input logic irw, input logic pcw, input logic br, input logic jl,
                     input logic jr, input logic tk, input logic [31:0] imm_v,
                     input logic [31:0] rs1_v, input logic [31:0] rd_v);
    logic [31:0] t, old_pc;
    ir_write = irw; pc_write = pcw; is_branch = br; is_jal = jl; is_jalr = jr;
    take_branch = tk; imm = imm_v; rs1_data = rs1_v; imem_rdata = rd_v;
    if (jr) t = (rs1_v + imm_v) & 32'hFFFF_FFFE;
    else if (jl || (br && tk)) t = m_pc_old + imm_v;
    else t = m_pc_old + 32'd4;
    @(posedge clk);
    old_pc = m_pc;
    if (pcw) begin
      if (t[1:0] == 2'b00) begin m_pc = t; m_instret = m_instret + 1; end
      else m_mis = 1'b1;
    end
    if (irw) begin m_pc_old = old_pc; m_instr = rd_v; end
    $display("t=%0t irw=%0b pcw=%0b br=%0b jal=%0b jalr=%0b tk=%0b imm=%08h rs1=%08h -> pc=%08h pc_old=%08h mis=%0b",
             $time, irw, pcw, br, jl, jr, tk, imm_v, rs1_v, m_pc, m_pc_old, m_mis);
    @(negedge clk);
    ir_write = 0; pc_write = 0;
  endtask

  initial begin
    rst = 1'b1;
    ir_write = 0; pc_write = 0; is_branch = 0; is_jal = 0; is_jalr = 0; take_branch = 0;
    imm = 0; rs1_data = 0; imem_rdata = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_pc", pc, 32'h0);
    chk("rst_opcode", {25'd0, opcode}, 32'h13);
    rst = 1'b0;
    @(negedge clk);

    // Sequential fetch
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 32'h0050_0093);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("seq_pc", pc, 32'h4);
    chk("seq_pc_old", pc_old, 32'h0);
    chk("seq_pc_plus4", pc_plus4, 32'h4);
    chk("seq_opcode", {25'd0, opcode}, 32'h13);
    chk("seq_instret", instret, 32'd1);

    // Branch taken / not taken from pc_old = 0x100
    cyc(0, 1, 0, 0, 1, 0, 0, 32'h100, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0063);
    cyc(0, 1, 1, 0, 0, 1, 32'hFFFF_FFF8, 0, 0);
    chk("br_taken_pc", pc, 32'hF8);
    cyc(0, 1, 1, 0, 0, 0, 32'hFFFF_FFF8, 0, 0);
    chk("br_not_taken_pc", pc, 32'h104);

    // JALR aligned, then misaligned, then a good commit keeps the sticky flag
    cyc(0, 1, 0, 0, 1, 0, 32'h2, 32'h203, 0);
    chk("jalr_pc", pc, 32'h204);
    cyc(0, 1, 0, 0, 1, 0, 32'h1, 32'h201, 0);
    chk("jalr_mis_pc", pc, 32'h204);
    chk("jalr_mis_flag", {31'd0, misaligned}, 32'd1);
    chk("jalr_mis_instret", instret, 32'd5);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("sticky_flag", {31'd0, misaligned}, 32'd1);
    chk("sticky_pc", pc, 32'h104);
    cyc(0, 1, 0, 1, 0, 0, 32'h2, 0, 0);
    chk("jal_mis_pc", pc, 32'h104);

    // JAL wrap with simultaneous ir_write
    cyc(0, 1, 0, 0, 1, 0, 0, 32'hFFFF_FFF0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 32'h0200_006F);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("pre_jal_pc", pc, 32'hFFFF_FFF4);
    cyc(1, 1, 0, 1, 0, 0, 32'h20, 0, 32'h0000_0033);
    chk("jal_wrap_pc", pc, 32'h10);
    chk("jal_pc_old", pc_old, 32'hFFFF_FFF4);
    chk("jal_pc_plus4", pc_plus4, 32'hFFFF_FFF8);
    chk("jal_opcode", {25'd0, opcode}, 32'h33);

    // pc_old + 4 wraps to zero
    cyc(0, 1, 0, 0, 1, 0, 0, 32'hFFFF_FFFC, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0013);
    chk("wrap_pc_plus4", pc_plus4, 32'h0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("wrap_pc", pc, 32'h0);

    // Asynchronous reset mid-cycle with pc = 0x40
    cyc(0, 1, 0, 0, 1, 0, 0, 32'h40, 0);
    chk("pre_rst_pc", pc, 32'h40);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("arst_pc", pc, 32'h0);
    chk("arst_opcode", {25'd0, opcode}, 32'h13);
    chk("arst_instret", instret, 32'h0);
    chk("arst_misaligned", {31'd0, misaligned}, 32'h0);
    ir_write = 1; pc_write = 1; is_jalr = 1; rs1_data = 32'h80; imm = 0; imem_rdata = 32'h0000_006F;
    @(posedge clk); #1;
    chk("rst_hold_pc", pc, 32'h0);
    chk("rst_hold_instr", instr, 32'h13);
    chk("rst_hold_instret", instret, 32'h0);
    ir_write = 0; pc_write = 0; is_jalr = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 16 accepted commits: the 4-bit counter wraps to zero
    for (int i = 0; i < 16; i++) cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("cnt16_instret", instret, 32'd16);
    chk("cnt4_wrap", {28'd0, instret4}, 32'd0);
    chk("cnt_pc", pc, 32'h4);

    @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter and instruction-register stage of the multicycle RV32I core, directly upstream of `control_unit`. Holds the PC, latches the fetched instruction word on `ir_write`, and drives `opcode` into the control FSM. Consumes the FSM's `pc_write`/`is_branch`/`is_jal`/`is_jalr` plus `take_branch` to select and commit the next PC. Also keeps a sticky misaligned-target flag and a retired-instruction counter.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC value loaded on reset.
- `CNT_W`, default `32`: width of the retired-instruction counter.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `ir_write`  in  1  latch `imem_rdata` into the instruction register and `pc` into `pc_old`.
- `pc_write`  in  1  commit the next PC.
- `is_branch`, `is_jal`, `is_jalr`  in  1 each  next-PC kind, driven by the control FSM.
- `take_branch`  in  1  branch comparison result.
- `imm`  in  32  sign-extended immediate of the current instruction.
- `rs1_data`  in  32  rs1 operand, used as the JALR base.
- `imem_rdata`  in  32  instruction memory read data for address `pc`.
- `pc`  out  32  fetch address (registered).
- `pc_old`  out  32  address of the instruction held in the IR (registered).
- `pc_plus4`  out  32  `pc_old + 4`, the link value (combinational).
- `instr`  out  32  instruction register (registered).
- `opcode`  out  7  `instr[6:0]`, feeds `control_unit`.
- `misaligned`  out  1  sticky flag: a committed target was not word-aligned.
- `instret`  out  CNT_W  count of accepted `pc_write` commits.

## Operation
Next-target selection (combinational), priority order:
- `is_jalr` → `(rs1_data + imm) & ~32'h1`.
- else `is_jal` → `pc_old + imm`.
- else `is_branch && take_branch` → `pc_old + imm`.
- else → `pc_old + 4`.

Arithmetic rules:
- All additions are 32-bit and wrap modulo 2^32; no overflow detection.
- `0xFFFF_FFFC + 4` yields `0x0000_0000`.

On `ir_write`:
- `instr <= imem_rdata`.
- `pc_old <= pc`. This is the pre-update `pc`, even when `pc_write` is asserted in the same cycle.

On `pc_write`:
- If `target[1:0] == 2'b00`: `pc <= target` and `instret <= instret + 1`. The counter wraps to 0 at 2^CNT_W.
- Otherwise `pc`, `pc_old` and `instret` hold, and `misaligned <= 1`.
- `misaligned` clears only on `rst`.

Simultaneous `ir_write` and `pc_write`:
- Both take effect.
- The target is computed from the pre-edge `pc_old`.

Reset values (applied immediately on `rst` assertion, including mid-instruction):
- `pc = RESET_PC`, `pc_old = RESET_PC`.
- `instr = 32'h0000_0013` (NOP), so `opcode = 7'b0010011`.
- `misaligned = 0`, `instret = 0`.

While `rst` is high, `ir_write` and `pc_write` are ignored.

## Timing
- All registered outputs change only at a rising edge where the corresponding enable is high, or at `rst` assertion.
- `opcode` is valid in the cycle after the `ir_write` edge. It is therefore available to the FSM's DECODE state.
- `pc_plus4` and the internal target settle combinationally within the same cycle as their inputs.
- Instruction memory is synchronous with one-cycle read latency. `imem_rdata` for `pc` is valid in the FETCH cycle in which `ir_write` is asserted.
- When `pc_write` is low, `is_*`, `take_branch`, `imm` and `rs1_data` are don't-care.

## Structure
- Shared package `riscv_pkg` holds:
  - the opcode localparams (LOAD, STORE, BRANCH, JAL, JALR, OP_IMM, OP, LUI, AUIPC, SYSTEM);
  - `XLEN = 32`;
  - `NOP_INSTR = 32'h0000_0013`.
- Sub-module `pc_target_calc` is purely combinational. It takes `pc_old`, `rs1_data`, `imm` and the select bits, and produces `target` and `target_misaligned`.
- The top level contains only the registers.

## Test plan
- **Reset:** assert `rst` mid-run with `pc = 0x40` → immediately `pc = 0`, `opcode = 7'b0010011`, `instret = 0`, `misaligned = 0`.
- **Sequential fetch:**
  - `ir_write` with `imem_rdata = 0x00500093`, then `pc_write` with no `is_*` → `pc = 4`, `pc_old = 0`, `pc_plus4 = 4`, `opcode = 7'b0010011`, `instret = 1`.
- **Branch:** `pc_old = 0x100`, `imm = -8`, `is_branch = 1`:
  - with `take_branch = 1` → `pc = 0xF8`;
  - with `take_branch = 0` → `pc = 0x104`.
- **JALR:** `rs1_data = 0x203`, `imm = 2` → target `0x205 & ~1 = 0x204`, accepted.
  - Then `rs1_data = 0x201`, `imm = 1` → target `0x202` is misaligned: `pc` holds, `misaligned = 1`, `instret` unchanged.
  - `misaligned` stays 1 after further good commits until `rst`.
- **JAL wrap:** `pc_old = 0xFFFF_FFF0`, `imm = 0x20`, `is_jal = 1` → `pc = 0x10`.
  - Same cycle with `ir_write` → `pc_old` takes the old `pc` value.
- **Counter wrap:** with `CNT_W = 4`, 16 accepted commits → `instret = 0`.
